// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared state encoding, attribute entry type and defaults for the sprite scheduler
package sprite_pkg;

  localparam int CORDW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic                        vis;
    logic signed [CORDW_DEF-1:0] y;
    logic signed [CORDW_DEF-1:0] x;
  } spr_attr_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// rtl/sprite_scheduler_if.sv - host/scheduler bundle; drop_cnt exists only with SPRITE_SCHED_DROP_CNT_EN
interface sprite_scheduler_if #(
  parameter int CORDW     = 16,
  parameter int NUM_SPR   = 16,
  parameter int NUM_SLOTS = 4
);
  localparam int IDW = $clog2(NUM_SPR);

  logic                        line;
  logic signed [CORDW-1:0]     line_y;
  logic                        wr_en;
  logic [IDW-1:0]              wr_addr;
  logic signed [CORDW-1:0]     wr_x;
  logic signed [CORDW-1:0]     wr_y;
  logic                        wr_vis;
  logic [NUM_SLOTS*CORDW-1:0]  slot_x;
  logic [NUM_SLOTS*CORDW-1:0]  slot_y;
  logic [NUM_SLOTS*IDW-1:0]    slot_id;
  logic [NUM_SLOTS-1:0]        slot_valid;
  logic                        sched_done;
  logic                        ovf;
  logic                        busy;

`ifdef SPRITE_SCHED_DROP_CNT_EN
  logic [7:0]                  drop_cnt;

  modport master (
    output line, line_y, wr_en, wr_addr, wr_x, wr_y, wr_vis,
    input  slot_x, slot_y, slot_id, slot_valid, sched_done, ovf, busy, drop_cnt
  );

  modport slave (
    input  line, line_y, wr_en, wr_addr, wr_x, wr_y, wr_vis,
    output slot_x, slot_y, slot_id, slot_valid, sched_done, ovf, busy, drop_cnt
  );
`else
  modport master (
    output line, line_y, wr_en, wr_addr, wr_x, wr_y, wr_vis,
    input  slot_x, slot_y, slot_id, slot_valid, sched_done, ovf, busy
  );

  modport slave (
    input  line, line_y, wr_en, wr_addr, wr_x, wr_y, wr_vis,
    output slot_x, slot_y, slot_id, slot_valid, sched_done, ovf, busy
  );
`endif

endinterface

// File: rtl/sprite_attr_table.sv
// rtl/sprite_attr_table.sv - sprite attribute register file, one sync write port, one async read port
module sprite_attr_table
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 16,
  parameter int IDW     = $clog2(NUM_SPR)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [IDW-1:0] wr_addr,
  input  spr_attr_t      wr_data,
  input  logic [IDW-1:0] rd_addr,
  output spr_attr_t      rd_data
);

  spr_attr_t mem [NUM_SPR];

  // Only vis is reset; coordinates of an invisible entry never matter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SPR; i++) begin
      if (rst) begin
        mem[i].vis <= 1'b0;
      end else if (wr_en && (wr_addr == IDW'(i))) begin
        mem[i] <= wr_data;
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - per-line sprite scheduler; SPRITE_SCHED_DROP_CNT_EN adds the drop_cnt counter
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int CORDW      = CORDW_DEF,
  parameter int NUM_SPR    = 16,
  parameter int NUM_SLOTS  = 4,
  parameter int SPR_HEIGHT = 8,
  parameter int SPR_SCALE  = 0
) (
  input logic               clk,
  input logic               rst,
  sprite_scheduler_if.slave bus
);

  localparam int IDW  = $clog2(NUM_SPR);
  localparam int CNTW = $clog2(NUM_SLOTS + 1);
  localparam logic [CNTW-1:0]         SLOTS_C  = CNTW'(NUM_SLOTS);
  localparam logic [IDW-1:0]          LAST_IDX = IDW'(NUM_SPR - 1);
  localparam logic signed [CORDW-1:0] HEIGHT_C = CORDW'(SPR_HEIGHT);

  sched_state_e state, state_nx;

  logic [IDW-1:0]          idx;
  logic [CNTW-1:0]         cnt;
  logic signed [CORDW-1:0] ly_r;
  logic                    ovf_r;
  logic [NUM_SLOTS-1:0]    sh_valid;
  logic signed [CORDW-1:0] sh_x  [NUM_SLOTS];
  logic signed [CORDW-1:0] sh_y  [NUM_SLOTS];
  logic [IDW-1:0]          sh_id [NUM_SLOTS];

  spr_attr_t               wr_attr, rd_attr;
  logic signed [CORDW-1:0] rd_x, rd_y, sub, diff;
  logic                    hit, start, scanning, do_commit;

  always_comb begin
    wr_attr     = '0;
    wr_attr.vis = bus.wr_vis;
    wr_attr.y   = CORDW_DEF'(bus.wr_y);
    wr_attr.x   = CORDW_DEF'(bus.wr_x);
  end

  sprite_attr_table #(
    .NUM_SPR (NUM_SPR),
    .IDW     (IDW)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (wr_attr),
    .rd_addr (idx),
    .rd_data (rd_attr)
  );

  // Distance into the sprite in unscaled rows; negative means line is above it.
  always_comb begin
    rd_x = CORDW'(rd_attr.x);
    rd_y = CORDW'(rd_attr.y);
    sub  = ly_r - rd_y;
    diff = sub >>> SPR_SCALE;
    hit  = rd_attr.vis && !diff[CORDW-1] && (diff < HEIGHT_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.line) state_nx = SCAN;
      SCAN:    if (bus.line) state_nx = SCAN;
               else if (idx == LAST_IDX) state_nx = COMMIT;
      COMMIT:  state_nx = bus.line ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A line pulse wins over everything, so a pending commit is dropped.
  always_comb begin
    start     = bus.line;
    scanning  = (state == SCAN) && !bus.line;
    do_commit = (state == COMMIT) && !bus.line;
    bus.busy  = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      cnt      <= '0;
      ly_r     <= '0;
      ovf_r    <= 1'b0;
      sh_valid <= '0;
    end else if (start) begin
      idx      <= '0;
      cnt      <= '0;
      ly_r     <= bus.line_y;
      ovf_r    <= 1'b0;
      sh_valid <= '0;
    end else if (scanning) begin
      if (hit) begin
        if (cnt != SLOTS_C) begin
          cnt <= cnt + CNTW'(1);
          for (int s = 0; s < NUM_SLOTS; s++) begin
            if (cnt == CNTW'(s)) sh_valid[s] <= 1'b1;
          end
        end else begin
          ovf_r <= 1'b1;
        end
      end
      if (idx != LAST_IDX) idx <= idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (scanning && hit) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (cnt == CNTW'(s)) begin
          sh_x[s]  <= rd_x;
          sh_y[s]  <= rd_y;
          sh_id[s] <= idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.slot_x     <= '0;
      bus.slot_y     <= '0;
      bus.slot_id    <= '0;
      bus.slot_valid <= '0;
      bus.sched_done <= 1'b0;
      bus.ovf        <= 1'b0;
    end else begin
      bus.sched_done <= do_commit;
      if (do_commit) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          bus.slot_x[s*CORDW +: CORDW] <= sh_x[s];
          bus.slot_y[s*CORDW +: CORDW] <= sh_y[s];
          bus.slot_id[s*IDW +: IDW]    <= sh_id[s];
        end
        bus.slot_valid <= sh_valid;
        bus.ovf        <= ovf_r;
      end
    end
  end

`ifdef SPRITE_SCHED_DROP_CNT_EN
  logic [7:0] drop_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r       <= '0;
      bus.drop_cnt <= '0;
    end else begin
      if (start) begin
        drop_r <= '0;
      end else if (scanning && hit && (cnt == SLOTS_C) && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end
      if (do_commit) bus.drop_cnt <= drop_r;
    end
  end
`endif

endmodule
